serial_cmp_ctrl: RTL and testbench
==================================

SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the operand width in bits; W SHALL be a multiple of 4 and at least 4, so N = W/4 nibbles.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request a compare; sampled only when busy=0.
REQ-005 abort  input  1  cancel an in-progress compare.
REQ-006 a  input  W  operand A, unsigned.
REQ-007 b  input  W  operand B, unsigned.
REQ-008 busy  output  1  compare in progress.
REQ-009 done  output  1  one-cycle pulse marking a valid new result.
REQ-010 y  output  3  result {gt,eq,lt}, one-hot when valid; bit order matches the 74HC85 cascade order used in the codebase.

Function
REQ-011 FSM states SHALL be IDLE and SCAN; busy SHALL be 1 exactly when the state is SCAN.
REQ-012 In IDLE with start=1 and abort=0, the block SHALL take the following actions at that edge:
- capture a and b into internal registers;
- set the nibble index to N-1;
- clear y to 000;
- enter SCAN.
REQ-013 In IDLE, abort=1 SHALL take priority over start: the request is ignored and the state stays IDLE.
REQ-014 In SCAN, each cycle SHALL compare one captured nibble pair, selected by the index, using an internal 4-bit magnitude compare; comparison is MSB nibble first.
REQ-015 If the nibble pair differs, at the next edge y SHALL become 100 (A nibble greater) or 001 (A nibble less), done SHALL become 1, and the state SHALL go to IDLE (early exit).
REQ-016 If the nibble pair is equal and the index is 0, at the next edge y SHALL become 010, done SHALL become 1, and the state SHALL go to IDLE.
REQ-017 If the nibble pair is equal and the index is greater than 0, the index SHALL decrement by 1 and the state SHALL stay SCAN.
REQ-018 Latency: with start accepted at edge T and the first differing nibble being the m-th examined (m = 1..N), y and done SHALL update at edge T+m. Equal operands give m = N.
REQ-019 done SHALL be high for exactly one cycle per completed compare; it SHALL clear at the following edge.
REQ-020 y SHALL hold its last value until the next accepted start, abort or reset.
REQ-021 In SCAN, abort=1 SHALL take the block to IDLE at the next edge, with y=000 and done=0, regardless of the current nibble result.
REQ-022 In SCAN, start SHALL be ignored.
REQ-023 Changes on a and b during SCAN SHALL NOT affect the result.
REQ-024 A start present in the done cycle (busy=0) SHALL be accepted, allowing back-to-back compares with no idle gap.
REQ-025 The result SHALL equal the unsigned relation {a>b, a==b, a<b} of the operands captured at the accepting edge.

Reset
REQ-026 With rst_n=0 at a rising edge, the next state SHALL be:
- state IDLE, busy=0;
- done=0, y=000;
- nibble index and operand registers cleared to 0.
REQ-027 Reset SHALL override start and abort, including when asserted mid-SCAN; no done pulse SHALL follow a reset.
REQ-028 After reset releases, the first start SHALL behave as in REQ-012.

Verification (W=16)
REQ-029 rst_n=0 for 2 cycles, start=1 held -> busy=0, done=0, y=000 throughout; first start after release accepted.
REQ-030 a=16'h8000, b=16'h7FFF, start pulse -> done at T+1, y=100, busy high for exactly 1 cycle.
REQ-031 a=b=16'h1234 -> done at T+4, y=010; then a=16'h12A4, b=16'h12B0 -> done at T+3, y=001.
REQ-032 a=b=16'hFFFF, abort=1 at the 2nd SCAN cycle -> busy=0 next cycle, no done, y=000; start and abort together in IDLE -> not accepted.
REQ-033 Change a and b every cycle while busy -> result matches the captured pair; start asserted in the done cycle -> new compare accepted with no gap.
REQ-034 200 random pairs ($random), back-to-back -> every y matches {a>b,a==b,a<b} of the captured pair, and every latency matches REQ-018.

Source files
------------

// File: rtl/serial_cmp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_cmp_ctrl
// Brief    : Nibble-serial unsigned magnitude comparator, MSB nibble first,
//            with early exit on the first differing nibble and abort support.
// Revision : 1.0 - initial release
// ============================================================================
module serial_cmp_ctrl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [2:0]   y
);

    localparam int              c_N        = W / 4;
    localparam int              c_IW       = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(c_N - 1);
    localparam logic [c_IW-1:0] c_IDX_ONE  = c_IW'(1);
    localparam logic [c_IW-1:0] c_IDX_ZERO = '0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [W-1:0]    r_a, r_b, w_a_nxt, w_b_nxt;
    logic [c_IW-1:0] r_idx, w_idx_nxt;
    logic            r_done, w_done_nxt;
    logic [2:0]      r_y, w_y_nxt;

    logic [3:0]      w_nib_a, w_nib_b;
    logic            w_gt, w_eq, w_lt;

    // Select the nibble pair addressed by the scan index.
    always_comb begin
        w_nib_a = r_a[3:0];
        w_nib_b = r_b[3:0];
        for (int i = 0; i < c_N; i++) begin
            if (r_idx == c_IW'(i)) begin
                w_nib_a = r_a[4*i +: 4];
                w_nib_b = r_b[4*i +: 4];
            end
        end
    end

    // 4-bit magnitude compare of the selected pair.
    assign w_gt = (w_nib_a > w_nib_b);
    assign w_lt = (w_nib_a < w_nib_b);
    assign w_eq = (w_nib_a == w_nib_b);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= c_IDX_ZERO;
            r_done  <= 1'b0;
            r_y     <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
            r_y     <= w_y_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        w_y_nxt     = r_y;

        case (r_state)
            S_IDLE: begin
                if (abort) begin
                    w_y_nxt = 3'b000;
                end else if (start) begin
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_idx_nxt   = c_LAST_IDX;
                    w_y_nxt     = 3'b000;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (abort) begin
                    w_y_nxt     = 3'b000;
                    w_state_nxt = S_IDLE;
                end else if (!w_eq) begin
                    // y is {gt, eq, lt}
                    w_y_nxt     = {w_gt, 1'b0, w_lt};
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_idx == c_IDX_ZERO) begin
                    w_y_nxt     = 3'b010;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_idx_nxt = r_idx - c_IDX_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (r_state == S_SCAN);
    assign done = r_done;
    assign y    = r_y;

endmodule
`default_nettype wire

// File: tb/tb_serial_cmp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_cmp_ctrl
// Brief    : Self-checking bench for serial_cmp_ctrl (W=16): vector table,
//            corner-case sequences and randomized back-to-back compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_cmp_ctrl;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [2:0]   y;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [2:0]   ey;
        int           elat;
    } vec_t;

    serial_cmp_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain unsigned relation, y = {gt, eq, lt}.
    function automatic logic [2:0] ref_y(input logic [W-1:0] x, input logic [W-1:0] z);
        if (x > z)  return 3'b100;
        if (x == z) return 3'b010;
        return 3'b001;
    endfunction

    // Reference: latency is the position (from the top) of the first differing nibble.
    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] z);
        logic [W-1:0] d;
        int top;
        d   = x ^ z;
        top = -1;
        for (int i = 0; i < W; i++)
            if (d[i]) top = i;
        if (top < 0) return N;
        return N - top / 4;
    endfunction

    task automatic scramble_inputs();
        a     = W'($urandom);
        b     = W'($urandom);
        start = 1'($urandom_range(0, 1));
    endtask

    // Call at a negedge with the DUT idle; returns at the negedge of the done cycle.
    task automatic do_cmp(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2:0] ey, input int elat,
                          input bit scr, input string name);
        int lat;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (scr) scramble_inputs();
        @(negedge clk);
        check({name, " busy_after_start"}, 32'(busy), 32'd1);
        lat = 0;
        for (int k = 1; k <= N + 2; k++) begin
            @(posedge clk);
            #1;
            if (scr) scramble_inputs();
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        check({name, " latency"}, 32'(lat), 32'(elat));
        check({name, " y"}, 32'(y), 32'(ey));
        check({name, " busy_at_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t         tbl [7];
        logic [W-1:0] ra, rb;
        int           mode;
        bit           saw_done;

        tbl[0] = '{16'h8000, 16'h7FFF, 3'b100, 1};
        tbl[1] = '{16'h1234, 16'h1234, 3'b010, 4};
        tbl[2] = '{16'h12A4, 16'h12B0, 3'b001, 3};
        tbl[3] = '{16'h0000, 16'h0000, 3'b010, 4};
        tbl[4] = '{16'h0000, 16'hFFFF, 3'b001, 1};
        tbl[5] = '{16'h0F00, 16'h0E00, 3'b100, 2};
        tbl[6] = '{16'hFFFF, 16'hFFFE, 3'b100, 4};

        // Reset held with start asserted.
        rst_n = 1'b0;
        start = 1'b1;
        a     = 16'h8000;
        b     = 16'h7FFF;
        repeat (2) begin
            @(negedge clk);
            check("reset busy", 32'(busy), 32'd0);
            check("reset done", 32'(done), 32'd0);
            check("reset y", 32'(y), 32'd0);
        end
        rst_n = 1'b1;
        do_cmp(16'h8000, 16'h7FFF, 3'b100, 1, 1'b0, "post_reset");

        // done lasts one cycle, y holds.
        @(negedge clk);
        check("done_clears", 32'(done), 32'd0);
        check("y_holds", 32'(y), 32'(3'b100));

        // Table, back-to-back.
        for (int i = 0; i < 7; i++)
            do_cmp(tbl[i].va, tbl[i].vb, tbl[i].ey, tbl[i].elat, 1'b0, $sformatf("vec%0d", i));

        // Abort in the second SCAN cycle.
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort y", 32'(y), 32'd0);
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort no_done", 32'(saw_done), 32'd0);

        // start together with abort in IDLE is not accepted.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort busy", 32'(busy), 32'd0);

        // Reset mid-SCAN.
        a     = 16'hFFFF;
        b     = 16'hFFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midscan_reset busy", 32'(busy), 32'd0);
        check("midscan_reset y", 32'(y), 32'd0);
        saw_done = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("midscan_reset quiet", 32'(saw_done), 32'd0);

        // Operands changing every cycle while busy.
        do_cmp(16'h1234, 16'h1234, 3'b010, 4, 1'b1, "scr_eq");
        do_cmp(16'h12A4, 16'h12B0, 3'b001, 3, 1'b1, "scr_lt");

        // Randomized back-to-back compares.
        for (int i = 0; i < 200; i++) begin
            mode = int'($urandom_range(0, 3));
            ra   = W'($urandom);
            case (mode)
                0:       rb = ra;
                1:       rb = ra ^ W'($urandom_range(1, 15));
                default: rb = W'($urandom);
            endcase
            do_cmp(ra, rb, ref_y(ra, rb), ref_lat(ra, rb), 1'b1, $sformatf("rand%0d", i));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
